aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001: The block SHALL be a single-clock design: one clock; reset is synchronous and active-low.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004: start  input  1  request to expand key_in; accepted only in IDLE.
REQ-005: key_in  input  128  cipher key; word w0 = key_in[127:96] … w3 = key_in[31:0], MSB byte first.
REQ-006: abort  input  1  terminates expansion and returns to IDLE.
REQ-007: sub_word_o  output  32  RotWord of current w3 = {w3[23:0], w3[31:24]}, driven to the external SubWord unit.
REQ-008: sub_word_i  input  32  SubWord(sub_word_o), returned combinationally in the same cycle.
REQ-009: rk_valid  output  1  rk_data/rk_idx hold a valid round key.
REQ-010: rk_ready  input  1  consumer accepts the round key when rk_valid & rk_ready.
REQ-011: rk_data  output  128  current round key.
REQ-012: rk_idx  output  4  round index of rk_data, 0..10.
REQ-013: busy  output  1  high in any state other than IDLE.
REQ-014: done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-015: The FSM SHALL have exactly two states: IDLE and EMIT.
REQ-016: IDLE & start -> EMIT; key register <= key_in, round counter <= 0, latched on that edge.
REQ-017: In EMIT, rk_valid SHALL be 1, rk_data SHALL equal the key register and rk_idx SHALL equal the round counter.
REQ-018: In EMIT, if rk_valid & rk_ready and round counter < 10, the block SHALL load the next round key and increment the counter in the same edge.
REQ-019: Next key: t = sub_word_i ^ {rcon(r+1), 24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'; r is the current counter value.
REQ-020: rcon(n) for n = 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex); any other n SHALL give 00.
REQ-021: EMIT, handshake with counter == 10 -> IDLE; done = 1 for the following cycle only.
REQ-022: With rk_ready held high, the block SHALL deliver one round key per cycle: 11 keys in 11 consecutive cycles after the start edge.
REQ-023: While rk_ready = 0, rk_data, rk_idx and rk_valid SHALL remain stable; no state change occurs.
REQ-024: start in EMIT SHALL be ignored, with no effect on key, counter or outputs.
REQ-025: abort SHALL have priority over the handshake and start: on the next edge the FSM goes to IDLE, rk_valid = 0, and done is not pulsed.
REQ-026: In IDLE, rk_valid = 0, busy = 0; rk_data and rk_idx retain their last values.
REQ-027: sub_word_o SHALL always reflect the key register's w3, independent of state.
REQ-028: The round counter SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-029: rst_n = 0 at a clock edge SHALL force IDLE, key register = 0, counter = 0, rk_valid = 0, busy = 0, done = 0.
REQ-030: Reset SHALL override start and abort in the same cycle, and SHALL discard any in-progress expansion.

Verification
REQ-031: FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready = 1 and a reference S-box on sub_word_i:
- rk_idx 0 = the key itself;
- rk_idx 1 = a0fafe1788542cb123a339392a6c7605;
- rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
- done pulses exactly one cycle after idx 10 is accepted.
REQ-032: Same key with rk_ready toggled pseudo-randomly: all 11 keys match REQ-031 values in order, and outputs stay stable whenever ready = 0.
REQ-033: start pulsed again at rk_idx 4 with a different key_in: the sequence continues unchanged with the original key.
REQ-034: abort at rk_idx 6: next cycle busy = 0, rk_valid = 0, no done; a new start then yields the correct rk_idx 0.
REQ-035: rst_n = 0 for one cycle at rk_idx 3 with start also high: all REQ-029 reset values hold, and start is not accepted in that cycle.
REQ-036: All-zero key: rk_idx 1 = 62636363626363636263636362636363 (FIPS-197 Appendix A check).

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round keys,
// one per valid/ready handshake, using an external combinational SubWord unit.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, key_in    begin expansion of key_in (accepted only in IDLE)
//   abort            return to IDLE immediately, no done pulse
//   sub_word_o/_i    RotWord(w3) out, SubWord of it back in the same cycle
//   rk_valid/ready   round key handshake
//   rk_data, rk_idx  current round key and its round index 0..10
//   busy, done       not-IDLE flag, one-cycle pulse after key 10 accepted
module aes_key_sched_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic [31:0]  sub_word_o,
    input  logic [31:0]  sub_word_i,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic         hs;
    logic [3:0]   cnt_inc;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // RotWord of w3; the SubWord result comes back on sub_word_i
    assign sub_word_o = {key_q[23:0], key_q[31:24]};

    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign rk_data  = key_q;
    assign rk_idx   = cnt_q;
    assign done     = done_q;

    assign hs      = rk_valid & rk_ready;
    assign cnt_inc = cnt_q + 4'd1;

    // Next round key, chained word by word
    assign t  = sub_word_i ^ {rcon(cnt_inc), 24'h0};
    assign n0 = key_q[127:96] ^ t;
    assign n1 = key_q[95:64]  ^ n0;
    assign n2 = key_q[63:32]  ^ n1;
    assign n3 = key_q[31:0]   ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort outranks start even while idle
                if (start && !abort) begin
                    state_d = EMIT;
                    key_d   = key_in;
                    cnt_d   = 4'd0;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    if (cnt_q < 4'd10) begin
                        key_d = {n0, n1, n2, n3};
                        cnt_d = cnt_inc;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: reference S-box and key
// expansion model, randomized ready, start/abort/reset interference.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         abort;
    logic [31:0]  sub_word_o;
    logic [31:0]  sub_word_i;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    logic [7:0]   sbox [256];
    logic [127:0] rk_model [11];
    logic         use_kat;
    logic [127:0] kat1, kat10;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .abort      (abort),
        .sub_word_o (sub_word_o),
        .sub_word_i (sub_word_i),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_idx     (rk_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sub_word_i = {sbox[sub_word_o[31:24]], sbox[sub_word_o[23:16]],
                      sbox[sub_word_o[15:8]], sbox[sub_word_o[7:0]]};
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb;
        for (int x = 0; x < 256; x++) begin
            xb = 8'(x);
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                      ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Textbook word-array expansion: w[i] = w[i-4] ^ f(w[i-1])
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            rk_model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_exp(input logic [127:0] key, input int rdy_pct,
                           input int start_at, input int abort_at);
        int   idx, cyc;
        logic rdy;
        logic [31:0] w3;
        expand(key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        idx = 0;
        cyc = 0;
        while (idx <= 10 && cyc < 300) begin
            w3 = rk_model[idx][31:0];
            check("valid", rk_valid, 1'b1);
            check("busy", busy, 1'b1);
            check("done_early", done, 1'b0);
            check("idx", rk_idx, idx);
            check("rk", rk_data, rk_model[idx]);
            check("subw_o", sub_word_o, {w3[23:0], w3[31:24]});
            if (use_kat && idx == 1) check("kat_rk1", rk_data, kat1);
            if (use_kat && idx == 10) check("kat_rk10", rk_data, kat10);
            rdy = ($urandom_range(99) < rdy_pct);
            rk_ready = rdy;
            if (idx == start_at) begin
                start  = 1'b1;
                key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (idx == abort_at) abort = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
            if (abort) begin
                abort = 1'b0;
                rk_ready = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_valid", rk_valid, 1'b0);
                check("abort_done", done, 1'b0);
                tick();
                check("abort_done2", done, 1'b0);
                check("abort_idle", busy, 1'b0);
                return;
            end
            if (rdy) idx++;
        end
        rk_ready = 1'b0;
        check("all_keys", idx, 11);
        if (rdy_pct == 100) check("cycles", cyc, 11);
        check("done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_valid", rk_valid, 1'b0);
        check("hold_rk", rk_data, rk_model[10]);
        check("hold_idx", rk_idx, 10);
        tick();
        check("done_once", done, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        use_kat  = 1'b0;
        kat1     = '0;
        kat10    = '0;
        rst_n    = 1'b0;
        start    = 1'b1;
        abort    = 1'b0;
        key_in   = FIPS_KEY;
        rk_ready = 1'b1;
        build_sbox();
        check("sbox_00", sbox[0], 8'h63);
        check("sbox_53", sbox[8'h53], 8'hed);
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rk", rk_data, 128'h0);
        check("rst_idx", rk_idx, 4'd0);
        rst_n    = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        tick();

        use_kat = 1'b1;
        kat1    = FIPS_RK1;
        kat10   = FIPS_RK10;
        run_exp(FIPS_KEY, 100, -1, -1);
        run_exp(FIPS_KEY, 50, -1, -1);
        run_exp(FIPS_KEY, 60, 4, -1);
        use_kat = 1'b0;

        run_exp(FIPS_KEY, 100, -1, 6);
        use_kat = 1'b1;
        run_exp(FIPS_KEY, 70, -1, -1);

        kat1 = ZERO_RK1;
        expand(128'h0);
        kat10 = rk_model[10];
        run_exp(128'h0, 100, -1, -1);
        use_kat = 1'b0;

        // reset mid-expansion with start asserted
        expand(FIPS_KEY);
        key_in   = FIPS_KEY;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        rk_ready = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_idx", rk_idx, 3);
        check("pre_rst_rk", rk_data, rk_model[3]);
        rst_n    = 1'b0;
        start    = 1'b1;
        key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        check("mrst_busy", busy, 1'b0);
        check("mrst_valid", rk_valid, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_rk", rk_data, 128'h0);
        check("mrst_idx", rk_idx, 4'd0);
        rst_n    = 1'b1;
        start    = 1'b0;
        rk_ready = 1'b0;
        tick();
        check("mrst_idle", busy, 1'b0);

        for (int n = 0; n < 4; n++)
            run_exp({$urandom(), $urandom(), $urandom(), $urandom()},
                    $urandom_range(30, 100), -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
